conv_loop_controller: RTL

- Next-generation convolution loop controller for the accelerator datapath.
- Sequences the x / y / ch_in / ch_out-group / ky / kx loop nest, handshakes operands from the external a/b streams, and drives the MAC array and partial-sum memory.
- Geometry (feature map, channels, kernel, stride) is latched at start rather than fixed at elaboration.
- Processes OUT_PAR output channels per MAC step and stalls on output backpressure.

---
 rtl/conv_loop_controller.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/conv_loop_controller.sv
// conv_loop_controller: sequences the x/y/ch_in/ch_out-group/ky/kx convolution loop nest and drives MAC and psum memory
module conv_loop_controller #(
    parameter int CNT_W       = 16,
    parameter int MAX_KERNEL  = 7,
    parameter int OUT_PAR     = 4,
    parameter int PSUM_ADDR_W = 12
) (
    input  logic                   clk,
    input  logic                   arst_in,
    input  logic                   start,
    input  logic [CNT_W-1:0]       cfg_width,
    input  logic [CNT_W-1:0]       cfg_height,
    input  logic [CNT_W-1:0]       cfg_in_ch,
    input  logic [CNT_W-1:0]       cfg_out_ch,
    input  logic [CNT_W-1:0]       cfg_kernel,
    input  logic [CNT_W-1:0]       cfg_stride,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    input  logic                   a_valid,
    input  logic                   b_valid,
    output logic                   a_ready,
    output logic                   b_ready,
    output logic                   mac_valid,
    output logic                   mac_accumulate_internal,
    output logic                   mac_accumulate_with_0,
    output logic                   psum_re,
    output logic [PSUM_ADDR_W-1:0] psum_raddr,
    output logic                   psum_we,
    output logic [PSUM_ADDR_W-1:0] psum_waddr,
    output logic [CNT_W-1:0]       x_out,
    output logic [CNT_W-1:0]       y_out,
    output logic [CNT_W-1:0]       ky_out,
    output logic [CNT_W-1:0]       kx_out,
    output logic [CNT_W-1:0]       inch_out,
    output logic [CNT_W-1:0]       outch_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       out_x,
    output logic [CNT_W-1:0]       out_y,
    output logic [CNT_W-1:0]       out_ch,
    output logic [OUT_PAR-1:0]     out_ch_mask
);
    localparam logic [1:0] IDLE = 2'd0, CHECK = 2'd1, RUN = 2'd2, FINISH = 2'd3;
    localparam int GSH = (OUT_PAR > 1) ? $clog2(OUT_PAR) : 0;
    logic [1:0] state;
    logic [CNT_W-1:0] w, h, ic, oc, k, s;
    logic [CNT_W-1:0] x, y, ci, co, ky, kx, ox, oy;
    logic step, tap0, kx_last, ky_last, co_last, ci_last, y_last, x_last, tap_last, cfg_bad;
    logic [OUT_PAR-1:0] mask_now;
    logic [PSUM_ADDR_W-1:0] group;
    assign busy = state != IDLE;
    assign a_ready = state == RUN && !(out_valid && !out_ready);
    assign b_ready = a_ready;
    assign step = a_valid && b_valid && a_ready;
    assign mac_valid = step;
    assign tap0 = ky == '0 && kx == '0;
    assign mac_accumulate_internal = !tap0;
    assign mac_accumulate_with_0 = ci == '0 && tap0;
    assign psum_re = step && tap0 && ci != '0;
    assign group = PSUM_ADDR_W'(co >> GSH);
    assign psum_raddr = group;
    assign {x_out, y_out, ky_out, kx_out, inch_out, outch_out} = {x, y, ky, kx, ci, co};
    assign kx_last = kx == k - CNT_W'(1);
    assign ky_last = ky == k - CNT_W'(1);
    assign tap_last = kx_last && ky_last;
    assign ci_last = ci == ic - CNT_W'(1);
    assign co_last = ({1'b0, co} + (CNT_W+1)'(OUT_PAR)) >= {1'b0, oc};
    assign x_last = ({2'b0, x} + {2'b0, s} + {2'b0, k}) > {2'b0, w};
    assign y_last = ({2'b0, y} + {2'b0, s} + {2'b0, k}) > {2'b0, h};
    assign cfg_bad = w == '0 || h == '0 || ic == '0 || oc == '0 || k == '0 || s == '0 ||
                     k > CNT_W'(MAX_KERNEL) || k > w || k > h;
    // lanes of the current group that map onto real output channels
    always_comb begin
        mask_now = '0;
        for (int i = 0; i < OUT_PAR; i++)
            mask_now[i] = ({1'b0, co} + (CNT_W+1)'(i)) < {1'b0, oc};
    end
    // job FSM: latch geometry, legality check, run, drain the last output before done
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state <= IDLE;
            {w, h, ic, oc, k, s} <= '0;
            cfg_err <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    {w, h, ic, oc, k, s} <= {cfg_width, cfg_height, cfg_in_ch, cfg_out_ch, cfg_kernel, cfg_stride};
                    cfg_err <= 1'b0;
                    state <= CHECK;
                end
                CHECK: begin
                    cfg_err <= cfg_bad;
                    state <= cfg_bad ? FINISH : RUN;
                end
                RUN: if (step && tap_last && co_last && ci_last && y_last && x_last) state <= FINISH;
                default: if (!out_valid) begin
                    done <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
    // loop nest counters, innermost kx carrying outward; ox/oy track x/stride and y/stride without dividing
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            {x, y, ci, co, ky, kx, ox, oy} <= '0;
        end else if (state == IDLE && start) begin
            {x, y, ci, co, ky, kx, ox, oy} <= '0;
        end else if (step) begin
            kx <= kx_last ? '0 : kx + CNT_W'(1);
            if (kx_last) ky <= ky_last ? '0 : ky + CNT_W'(1);
            if (tap_last) co <= co_last ? '0 : co + CNT_W'(OUT_PAR);
            if (tap_last && co_last) ci <= ci_last ? '0 : ci + CNT_W'(1);
            if (tap_last && co_last && ci_last) begin
                y <= y_last ? '0 : y + s;
                oy <= y_last ? '0 : oy + CNT_W'(1);
            end
            if (tap_last && co_last && ci_last && y_last) begin
                x <= x_last ? '0 : x + s;
                ox <= x_last ? '0 : ox + CNT_W'(1);
            end
        end
    end
    // psum write-back and output-group capture, held until downstream accepts
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            psum_we <= 1'b0;
            psum_waddr <= '0;
            out_valid <= 1'b0;
            {out_x, out_y, out_ch} <= '0;
            out_ch_mask <= '0;
        end else begin
            psum_we <= step && tap_last && !ci_last;
            if (step && tap_last) psum_waddr <= group;
            if (step && tap_last && ci_last) begin
                out_valid <= 1'b1;
                {out_x, out_y, out_ch} <= {ox, oy, co};
                out_ch_mask <= mask_now;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
